pal_write_ctrl: RTL

Host-side write engine for the 256×16 palette RAM. Accepts byte-wide CPU writes (index, low byte, high byte) and packs them into 16-bit entries with auto-incrementing index. Buffers entries in a small FIFO and replays them into the RAM's edge-triggered write port only during free video slots. Owns the RAM's shared address port, muxing between the video index and the pending write address.

---
 rtl/pal_pkg.sv | 21 ++
 rtl/pal_fifo.sv | 55 +++++
 rtl/pal_write_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pal_pkg.sv
// Shared types for the palette write engine: FSM states, host register codes
// and the FIFO entry format.
package pal_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wr_state_t;

    localparam logic [1:0] SEL_INDEX = 2'd0;
    localparam logic [1:0] SEL_LO    = 2'd1;
    localparam logic [1:0] SEL_HI    = 2'd2;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } pal_entry_t;

endpackage

// File: rtl/pal_fifo.sv
// Small synchronous FIFO of palette entries; a full FIFO still accepts a push
// in a cycle that also pops.
module pal_fifo
    import pal_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  pal_entry_t                    din,
    output pal_entry_t                    head,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

    pal_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pal_write_ctrl.sv
// Host-side palette write engine: packs byte writes into 16-bit entries,
// queues them, and replays them into the palette RAM during free video slots.
module pal_write_ctrl
    import pal_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          nRESET,
    input  logic                          HWR,
    input  logic [1:0]                    HSEL,
    input  logic [7:0]                    HDI,
    output logic                          HBUSY,
    output logic                          HOVF,
    output logic [$clog2(FIFO_DEPTH):0]   HLEVEL,
    input  logic                          VSLOT,
    input  logic [7:0]                    VIDX,
    output logic [7:0]                    PAL_A,
    output logic [15:0]                   PAL_DI,
    output logic                          PAL_WR
);

    wr_state_t  state;
    wr_state_t  state_nxt;
    logic [7:0] index;
    logic [7:0] lo;
    logic [7:0] wr_addr;
    logic       commit;
    logic       accept;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       load;
    logic       wr_next;
    pal_entry_t head;
    pal_entry_t push_entry;

    assign commit     = HWR && (HSEL == SEL_HI);
    // The pop in STROBE frees a slot in the same cycle, so a full FIFO still takes the commit.
    assign accept     = !fifo_full || fifo_pop;
    assign fifo_push  = commit && accept;
    assign push_entry = '{addr: index, data: {HDI, lo}};
    assign HBUSY      = fifo_full;

    pal_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (nRESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .head  (head),
        .level (HLEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            index <= '0;
            lo    <= '0;
            HOVF  <= 1'b0;
        end else if (HWR) begin
            case (HSEL)
                SEL_INDEX: begin
                    index <= HDI;
                    HOVF  <= 1'b0;
                end
                SEL_LO: lo <= HDI;
                SEL_HI: begin
                    if (accept) index <= index + 8'd1;
                    else        HOVF  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty && VSLOT) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    state_nxt = (!fifo_empty && VSLOT) ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Head is popped as STROBE ends, so in HOLD the head is already the next entry.
    always_comb begin
        fifo_pop = (state == STROBE);
        load     = (state_nxt == SETUP);
        wr_next  = (state_nxt == STROBE);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            PAL_WR  <= 1'b0;
            wr_addr <= '0;
            PAL_DI  <= '0;
        end else begin
            PAL_WR <= wr_next;
            if (load) begin
                wr_addr <= head.addr;
                PAL_DI  <= head.data;
            end
        end
    end

    assign PAL_A = (state == IDLE) ? VIDX : wr_addr;

endmodule
